ro_count_reader: RTL and testbench

Measurement-window controller and reader for the ring-oscillator edge counter (`nBitCounter`, 8-bit `count`, sync active-low reset). On a start request it clears the counter through its reset input. It then samples `count` every cycle for a fixed window and extends the 8-bit value with a wrap counter. It presents the extended result with a one-cycle valid pulse. It sits between the counter and the host/readout logic, on the counter's clock.

---
 rtl/ro_count_reader.sv | 110 +++++++++++
 tb/tb_ro_count_reader.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/ro_count_reader.sv
// Measurement-window controller for the ring-oscillator edge counter: clears it, samples a
// fixed window, extends the 8-bit count with a wrap counter. Define RO_READER_CONT_EN for free-running mode.
module ro_count_reader #(
  parameter int unsigned WINDOW   = 100,
  parameter int unsigned RESULT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [7:0]          count,
  output logic                cnt_rst_n,
  output logic                busy,
  output logic                valid,
  output logic [RESULT_W-1:0] result,
  output logic                ovf
);

  localparam int unsigned WRAP_W = RESULT_W - 8;
  localparam logic [15:0] WIN_LAST = 16'(WINDOW - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, MEASURE, DONE} state_t;

  state_t            state_reg;
  logic              clr_phase_reg;
  logic [15:0]       win_cnt_reg;
  logic [7:0]        prev_reg;
  logic [WRAP_W-1:0] wraps_reg;
  logic              ovf_flag_reg;

  logic              wrap_hit;
  logic              wrap_sat;
  logic [WRAP_W-1:0] wraps_next;
  logic              ovf_flag_next;

  // A decrease between consecutive samples means the 8-bit counter rolled over once.
  always_comb begin
    wrap_hit      = (count < prev_reg);
    wrap_sat      = &wraps_reg;
    wraps_next    = wraps_reg;
    ovf_flag_next = ovf_flag_reg;
    if (wrap_hit) begin
      if (wrap_sat) ovf_flag_next = 1'b1;
      else          wraps_next    = wraps_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      clr_phase_reg <= 1'b0;
      win_cnt_reg   <= '0;
      prev_reg      <= '0;
      wraps_reg     <= '0;
      ovf_flag_reg  <= 1'b0;
      cnt_rst_n     <= 1'b1;
      busy          <= 1'b0;
      valid         <= 1'b0;
      result        <= '0;
      ovf           <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg     <= CLEAR;
            clr_phase_reg <= 1'b0;
            cnt_rst_n     <= 1'b0;
            busy          <= 1'b1;
          end
        end
        CLEAR: begin
          win_cnt_reg   <= '0;
          prev_reg      <= '0;
          wraps_reg     <= '0;
          ovf_flag_reg  <= 1'b0;
          clr_phase_reg <= 1'b1;
          if (clr_phase_reg) begin
            state_reg <= MEASURE;
            cnt_rst_n <= 1'b1;
          end
        end
        MEASURE: begin
          prev_reg     <= count;
          wraps_reg    <= wraps_next;
          ovf_flag_reg <= ovf_flag_next;
          win_cnt_reg  <= win_cnt_reg + 16'd1;
          if (win_cnt_reg == WIN_LAST) begin
            state_reg <= DONE;
            valid     <= 1'b1;
            busy      <= 1'b0;
            result    <= ovf_flag_next ? '1 : {wraps_next, count};
            ovf       <= ovf_flag_next;
          end
        end
        DONE: begin
`ifdef RO_READER_CONT_EN
          state_reg     <= CLEAR;
          clr_phase_reg <= 1'b0;
          cnt_rst_n     <= 1'b0;
          busy          <= 1'b1;
`else
          state_reg <= IDLE;
`endif
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ro_count_reader.sv
// Directed bench for ro_count_reader: three instances (basic, wrap, overflow) each driving
// its own model of the nBitCounter that increments every cycle.
module tb_ro_count_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] start;
  logic [2:0] crn;
  logic [2:0] busy_v;
  logic [2:0] valid_v;
  logic [2:0] ovf_v;
  logic [7:0] cnt [3];
  logic [15:0] res0, res1;
  logic [8:0]  res2;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    initial cnt[gi] = 8'd0;
    always_ff @(posedge clk) begin
      if (!crn[gi]) cnt[gi] <= 8'd0;
      else          cnt[gi] <= cnt[gi] + 8'd1;
    end
  end

  ro_count_reader #(.WINDOW(100), .RESULT_W(16)) u_basic (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .count(cnt[0]), .cnt_rst_n(crn[0]),
    .busy(busy_v[0]), .valid(valid_v[0]), .result(res0), .ovf(ovf_v[0]));
  ro_count_reader #(.WINDOW(300), .RESULT_W(16)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .count(cnt[1]), .cnt_rst_n(crn[1]),
    .busy(busy_v[1]), .valid(valid_v[1]), .result(res1), .ovf(ovf_v[1]));
  ro_count_reader #(.WINDOW(1000), .RESULT_W(9)) u_ovf (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .count(cnt[2]), .cnt_rst_n(crn[2]),
    .busy(busy_v[2]), .valid(valid_v[2]), .result(res2), .ovf(ovf_v[2]));

  function automatic logic [15:0] res_of(input int i);
    case (i)
      0:       return res0;
      1:       return res1;
      default: return {7'd0, res2};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts instance i and waits for its valid; latency counts cycles from the start-sampling cycle.
  task automatic measure(input int i, input int w, input logic [15:0] exp_res,
                         input logic exp_ovf, input string tag);
    int lat;
    int lows;
    start[i] = 1'b1;
    tick();
    start[i] = 1'b0;
    lat = 1;
    lows = 0;
    check({tag, "_busy_rise"}, {31'd0, busy_v[i]}, 32'd1);
    while (!valid_v[i] && lat < w + 20) begin
      if (!crn[i]) lows++;
      tick();
      lat++;
    end
    $display("%s: valid at latency %0d result 0x%0h ovf %0d", tag, lat, res_of(i), ovf_v[i]);
    check({tag, "_latency"}, lat, w + 3);
    check({tag, "_clr_cycles"}, lows, 2);
    check({tag, "_result"}, {16'd0, res_of(i)}, {16'd0, exp_res});
    check({tag, "_ovf"}, {31'd0, ovf_v[i]}, {31'd0, exp_ovf});
    check({tag, "_busy_done"}, {31'd0, busy_v[i]}, 32'd0);
    tick();
    check({tag, "_valid_pulse"}, {31'd0, valid_v[i]}, 32'd0);
  endtask

  initial begin
    int n;
    int lat;
    rst_n = 1'b0;
    start = 3'b111;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst%0d_cnt_rst_n", i), {31'd0, crn[i]}, 32'd1);
      check($sformatf("rst%0d_busy", i), {31'd0, busy_v[i]}, 32'd0);
      check($sformatf("rst%0d_valid", i), {31'd0, valid_v[i]}, 32'd0);
      check($sformatf("rst%0d_result", i), {16'd0, res_of(i)}, 32'd0);
      check($sformatf("rst%0d_ovf", i), {31'd0, ovf_v[i]}, 32'd0);
    end
    rst_n = 1'b1;
    start = 3'b000;
    repeat (2) tick();

`ifdef RO_READER_CONT_EN
    measure(0, 100, 16'd99, 1'b0, "cont_first");
    for (int k = 0; k < 3; k++) begin
      lat = 1;
      while (!valid_v[0] && lat < 200) begin
        tick();
        lat++;
      end
      $display("cont%0d: interval %0d result %0d", k, lat, res0);
      check($sformatf("cont%0d_interval", k), lat, 103);
      check($sformatf("cont%0d_result", k), {16'd0, res0}, 32'd99);
      check($sformatf("cont%0d_busy", k), {31'd0, busy_v[0]}, 32'd0);
      tick();
    end
`else
    measure(0, 100, 16'd99, 1'b0, "basic");
    tick();
    measure(1, 300, 16'd299, 1'b0, "wrap");
    tick();
    measure(2, 1000, 16'h01FF, 1'b1, "overflow");
    tick();

    // Second start during MEASURE must be dropped.
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (30) tick();
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    n = 0;
    for (int c = 0; c < 200; c++) begin
      if (valid_v[0]) n++;
      tick();
    end
    $display("ignored_start: %0d valid pulses result %0d", n, res0);
    check("ignored_start_valids", n, 1);
    check("ignored_start_result", {16'd0, res0}, 32'd99);

    // Abort at MEASURE cycle 50 (MEASURE begins at latency 3).
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (51) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_result", {16'd0, res0}, 32'd0);
    check("abort_busy", {31'd0, busy_v[0]}, 32'd0);
    check("abort_cnt_rst_n", {31'd0, crn[0]}, 32'd1);
    n = 0;
    for (int c = 0; c < 150; c++) begin
      if (valid_v[0]) n++;
      tick();
    end
    $display("abort: %0d valid pulses after reset", n);
    check("abort_no_valid", n, 0);
    measure(0, 100, 16'd99, 1'b0, "after_abort");
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
